// File: rtl/lcd_frame_sequencer.sv
// HD44780 8-bit write-only sequencer: power-up wait, four-command init, then
// one MM:SS / fraction frame per (coalesced) refresh request.
module lcd_frame_sequencer #(
   parameter int POWERUP_CYC    = 750000,
   parameter int EN_HIGH_CYC    = 25,
   parameter int CHAR_WAIT_CYC  = 2500,
   parameter int CLEAR_WAIT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       update,
   input  logic [7:0] char1,
   input  logic [7:0] char2,
   input  logic [7:0] char3,
   input  logic [7:0] char4,
   input  logic [7:0] char5,
   input  logic [7:0] char6,
   input  logic [7:0] char7,
   output logic [7:0] lcd_data,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_en,
   output logic       busy,
   output logic       frame_done
);

   localparam int MAX_A = (POWERUP_CYC > CLEAR_WAIT_CYC) ? POWERUP_CYC : CLEAR_WAIT_CYC;
   localparam int MAX_B = (CHAR_WAIT_CYC > EN_HIGH_CYC) ? CHAR_WAIT_CYC : EN_HIGH_CYC;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] PWR_LAST   = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_HIGH_CYC - 1);
   localparam logic [CNT_W-1:0] CHAR_LAST  = CNT_W'(CHAR_WAIT_CYC - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

   typedef enum logic [1:0] {PWR_WAIT, INIT, IDLE, FRAME} top_t;
   typedef enum logic [1:0] {SETUP, PULSE, WAIT} phase_t;

   top_t             state_reg, state_next;
   phase_t           phase_reg, phase_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic [3:0]       idx_reg, idx_next;
   logic             pend_reg, pend_next;
   logic [7:0]       data_reg, data_next;
   logic             rs_reg, rs_next;
   logic             en_reg, en_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             snap_load;
   logic             start_frame;
   logic             last_write;
   logic [CNT_W-1:0] wait_last;
   logic [3:0]       nxt_idx;
   logic [8:0]       next_word;

   logic [7:0] live [7];
   logic [7:0] snap_reg [7];

   assign live[0] = char1;
   assign live[1] = char2;
   assign live[2] = char3;
   assign live[3] = char4;
   assign live[4] = char5;
   assign live[5] = char6;
   assign live[6] = char7;

   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_snap
         always_ff @(posedge clk) begin
            if (!rst_n)
               snap_reg[gi] <= 8'h00;
            else if (snap_load)
               snap_reg[gi] <= live[gi];
         end
      end
   endgenerate

   // {rs, data} of the write following idx_reg in the current sequence
   always_comb begin
      nxt_idx   = idx_reg + 4'd1;
      next_word = 9'h000;
      if (state_reg == INIT) begin
         case (nxt_idx)
            4'd1:    next_word = 9'h00C;
            4'd2:    next_word = 9'h006;
            4'd3:    next_word = 9'h001;
            default: next_word = 9'h038;
         endcase
      end else begin
         case (nxt_idx)
            4'd1:    next_word = {1'b1, snap_reg[0]};
            4'd2:    next_word = {1'b1, snap_reg[1]};
            4'd3:    next_word = {1'b1, snap_reg[2]};
            4'd4:    next_word = {1'b1, snap_reg[3]};
            4'd5:    next_word = {1'b1, snap_reg[4]};
            4'd6:    next_word = 9'h0C0;
            4'd7:    next_word = {1'b1, snap_reg[5]};
            4'd8:    next_word = {1'b1, snap_reg[6]};
            default: next_word = 9'h080;
         endcase
      end
   end

   always_comb begin
      state_next  = state_reg;
      phase_next  = phase_reg;
      cnt_next    = cnt_reg;
      idx_next    = idx_reg;
      pend_next   = pend_reg;
      data_next   = data_reg;
      rs_next     = rs_reg;
      en_next     = en_reg;
      busy_next   = busy_reg;
      done_next   = 1'b0;
      snap_load   = 1'b0;
      start_frame = 1'b0;
      last_write  = (state_reg == INIT) ? (idx_reg == 4'd3) : (idx_reg == 4'd8);
      wait_last   = (state_reg == INIT && idx_reg == 4'd3) ? CLEAR_LAST : CHAR_LAST;

      case (state_reg)
         PWR_WAIT: begin
            pend_next = pend_reg | update;
            if (cnt_reg == PWR_LAST) begin
               state_next         = INIT;
               phase_next         = SETUP;
               cnt_next           = '0;
               idx_next           = 4'd0;
               {rs_next, data_next} = 9'h038;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         IDLE: begin
            if (update || pend_reg)
               start_frame = 1'b1;
            else
               busy_next = 1'b0;
         end
         default: begin
            pend_next = pend_reg | update;
            case (phase_reg)
               SETUP: begin
                  phase_next = PULSE;
                  en_next    = 1'b1;
                  cnt_next   = '0;
               end
               PULSE: begin
                  if (cnt_reg == EN_LAST) begin
                     phase_next = WAIT;
                     en_next    = 1'b0;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
               default: begin
                  if (cnt_reg == wait_last) begin
                     cnt_next = '0;
                     if (!last_write) begin
                        idx_next             = idx_reg + 4'd1;
                        phase_next           = SETUP;
                        {rs_next, data_next} = next_word;
                     end else if (state_reg == INIT) begin
                        if (pend_reg || update) begin
                           start_frame = 1'b1;
                        end else begin
                           state_next = IDLE;
                           busy_next  = 1'b0;
                        end
                     end else begin
                        // A pending request keeps busy high through the
                        // frame_done cycle; IDLE then starts the next frame.
                        state_next = IDLE;
                        done_next  = 1'b1;
                        busy_next  = pend_reg | update;
                     end
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            endcase
         end
      endcase

      if (start_frame) begin
         state_next           = FRAME;
         phase_next           = SETUP;
         cnt_next             = '0;
         idx_next             = 4'd0;
         {rs_next, data_next} = 9'h080;
         busy_next            = 1'b1;
         pend_next            = 1'b0;
         snap_load            = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= PWR_WAIT;
         phase_reg <= SETUP;
         cnt_reg   <= '0;
         idx_reg   <= 4'd0;
         pend_reg  <= 1'b0;
         data_reg  <= 8'h00;
         rs_reg    <= 1'b0;
         en_reg    <= 1'b0;
         busy_reg  <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         phase_reg <= phase_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         pend_reg  <= pend_next;
         data_reg  <= data_next;
         rs_reg    <= rs_next;
         en_reg    <= en_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   assign lcd_data   = data_reg;
   assign lcd_rs     = rs_reg;
   assign lcd_rw     = 1'b0;
   assign lcd_en     = en_reg;
   assign busy       = busy_reg;
   assign frame_done = done_reg;

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Bench for lcd_frame_sequencer: a negedge monitor logs LCD writes and
// pulses; directed steps compare them with frames built from the characters.
module tb_lcd_frame_sequencer;

   localparam int PW  = 20;
   localparam int EH  = 2;
   localparam int CWT = 5;
   localparam int CLW = 10;
   localparam int WR_LEN    = 1 + EH + CWT;
   localparam int INIT_LEN  = PW + 3 * WR_LEN + (1 + EH + CLW);
   localparam int FRAME_LEN = 9 * WR_LEN;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       update = 1'b0;
   logic [7:0] ch [7];
   logic [7:0] lcd_data;
   logic       lcd_rs, lcd_rw, lcd_en, busy, frame_done;

   always #5 clk = ~clk;

   lcd_frame_sequencer #(
      .POWERUP_CYC(PW), .EN_HIGH_CYC(EH),
      .CHAR_WAIT_CYC(CWT), .CLEAR_WAIT_CYC(CLW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .update(update),
      .char1(ch[0]), .char2(ch[1]), .char3(ch[2]), .char4(ch[3]),
      .char5(ch[4]), .char6(ch[5]), .char7(ch[6]),
      .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
      .lcd_en(lcd_en), .busy(busy), .frame_done(frame_done)
   );

   int         cyc = 0;
   int         width = 0;
   logic       en_prev = 1'b0;
   logic       busy_prev = 1'b1;
   logic [8:0] wr_q[$];
   int         wcyc_q[$];
   int         width_q[$];
   int         done_q[$];
   int         bfall_q[$];
   logic [8:0] exp_q[$];

   always @(negedge clk) begin
      cyc++;
      if (lcd_en === 1'b1 && en_prev === 1'b0) begin
         wr_q.push_back({lcd_rs, lcd_data});
         wcyc_q.push_back(cyc);
         width = 0;
      end
      if (lcd_en === 1'b1) width++;
      if (lcd_en === 1'b0 && en_prev === 1'b1) width_q.push_back(width);
      if (frame_done === 1'b1) done_q.push_back(cyc);
      if (busy === 1'b0 && busy_prev === 1'b1) bfall_q.push_back(cyc);
      en_prev   = lcd_en;
      busy_prev = busy;
   end

   int n_cmp = 0;
   int n_bad = 0;
   int mark  = 0;
   int base  = 0;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d (0x%0h) required %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic clear_mon();
      wr_q.delete(); wcyc_q.delete(); width_q.delete();
      done_q.delete(); bfall_q.delete(); exp_q.delete();
   endtask

   task automatic add_init_exp();
      exp_q.push_back(9'h038); exp_q.push_back(9'h00C);
      exp_q.push_back(9'h006); exp_q.push_back(9'h001);
   endtask

   // A frame is the line-1 address, five line-1 characters, the line-2
   // address and two line-2 characters, taken from the current ch values.
   task automatic add_frame_exp();
      exp_q.push_back(9'h080);
      for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, ch[i]});
      exp_q.push_back(9'h0C0);
      exp_q.push_back({1'b1, ch[5]});
      exp_q.push_back({1'b1, ch[6]});
   endtask

   task automatic check_writes(input string tag);
      int n;
      check($sformatf("%s_nwrites", tag), wr_q.size(), exp_q.size());
      n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_w%0d", tag, i), int'(wr_q[i]), int'(exp_q[i]));
      check($sformatf("%s_npulses", tag), width_q.size(), wr_q.size());
      for (int i = 0; i < width_q.size(); i++)
         check($sformatf("%s_width%0d", tag, i), width_q[i], EH);
   endtask

   task automatic set_chars(input logic [7:0] a, b, c, d, e, f, g);
      ch[0] = a; ch[1] = b; ch[2] = c; ch[3] = d; ch[4] = e; ch[5] = f; ch[6] = g;
   endtask

   task automatic rand_chars();
      for (int i = 0; i < 7; i++) ch[i] = 8'($urandom_range(0, 255));
   endtask

   // Called at posedge+1; update is sampled at the following edge.
   task automatic pulse_update();
      update = 1'b1;
      @(posedge clk); #1;
      update = 1'b0;
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check({tag, "_rst_en"}, int'(lcd_en), 0);
      check({tag, "_rst_data"}, int'(lcd_data), 0);
      check({tag, "_rst_rs"}, int'(lcd_rs), 0);
      check({tag, "_rst_rw"}, int'(lcd_rw), 0);
      check({tag, "_rst_busy"}, int'(busy), 1);
      check({tag, "_rst_done"}, int'(frame_done), 0);
      rst_n = 1'b1;
      mark = cyc + 1;
      @(negedge clk); #1;
      clear_mon();
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy !== 1'b0) check({tag, "_timeout_busy"}, int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_writes(input string tag, input int count, input int budget);
      int n = 0;
      while (wr_q.size() < count && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (wr_q.size() < count) check({tag, "_timeout_writes"}, wr_q.size(), count);
   endtask

   initial begin
      set_chars("0", "0", ":", "0", "0", "0", "0");

      // Power-up init with no request
      do_reset("init");
      add_init_exp();
      wait_idle("init", 200);
      check_writes("init");
      check("init_nbfall", bfall_q.size(), 1);
      if (bfall_q.size() > 0) check("init_bfall_cyc", bfall_q[0] - mark, INIT_LEN);
      check("init_ndone", done_q.size(), 0);

      // Single frame; live characters change during the third write
      clear_mon();
      set_chars("1", "2", ":", "3", "4", "0", "8");
      add_frame_exp();
      base = cyc;
      pulse_update();
      check("req_busy", int'(busy), 1);
      check("req_word", int'({lcd_rs, lcd_data}), 9'h080);
      check("req_en", int'(lcd_en), 0);
      wait_writes("snap", 3, 100);
      set_chars("5", "9", ":", "5", "9", "9", "9");
      wait_idle("frame", 200);
      check_writes("frame");
      if (wcyc_q.size() > 0) check("frame_en_rise", wcyc_q[0] - base, 3);
      check("frame_ndone", done_q.size(), 1);
      if (done_q.size() > 0) begin
         check("frame_len", done_q[0] - (base + 2), FRAME_LEN);
         check("frame_bfall_nb", bfall_q.size(), 1);
         if (bfall_q.size() > 0) check("frame_bfall_cyc", bfall_q[0], done_q[0]);
      end

      // Three requests during a frame collapse to one extra frame
      clear_mon();
      rand_chars();
      add_frame_exp();
      base = cyc;
      pulse_update();
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(5, 15)) @(posedge clk);
         #1;
         pulse_update();
      end
      rand_chars();
      add_frame_exp();
      wait_idle("coal", 400);
      check_writes("coal");
      if (wcyc_q.size() > 0) check("coal_en_rise", wcyc_q[0] - base, 3);
      check("coal_ndone", done_q.size(), 2);
      if (done_q.size() == 2 && wcyc_q.size() > 9) begin
         check("coal_gap", done_q[1] - done_q[0], FRAME_LEN + 1);
         check("coal_next_en", wcyc_q[9] - done_q[0], 2);
         check("coal_nbfall", bfall_q.size(), 1);
         if (bfall_q.size() > 0) check("coal_bfall", bfall_q[0], done_q[1]);
      end

      // Request on the very last cycle of a frame
      clear_mon();
      rand_chars();
      add_frame_exp();
      base = cyc;
      pulse_update();
      repeat (FRAME_LEN - 1) @(posedge clk);
      #1;
      rand_chars();
      add_frame_exp();
      pulse_update();
      wait_idle("edge", 400);
      check_writes("edge");
      check("edge_ndone", done_q.size(), 2);
      if (done_q.size() == 2 && wcyc_q.size() > 9) begin
         check("edge_done0", done_q[0] - base, FRAME_LEN + 2);
         check("edge_next_en", wcyc_q[9] - done_q[0], 2);
         check("edge_nbfall", bfall_q.size(), 1);
      end

      // Request during power-up wait: frame follows init directly
      rand_chars();
      do_reset("pwr");
      add_init_exp();
      add_frame_exp();
      pulse_update();
      wait_idle("pwr", 400);
      check_writes("pwr");
      if (wcyc_q.size() > 4) check("pwr_frame_en", wcyc_q[4] - mark, INIT_LEN + 1);
      check("pwr_nbfall", bfall_q.size(), 1);
      if (bfall_q.size() > 0) check("pwr_bfall", bfall_q[0] - mark, INIT_LEN + FRAME_LEN);
      check("pwr_ndone", done_q.size(), 1);
      if (done_q.size() > 0) check("pwr_done", done_q[0] - mark, INIT_LEN + FRAME_LEN);

      // Reset mid-pulse with a request pending: pending frame is lost
      clear_mon();
      rand_chars();
      pulse_update();
      wait_writes("mid", 3, 100);
      pulse_update();
      begin
         int n = 0;
         while (lcd_en !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
         end
         check("mid_en_high", int'(lcd_en), 1);
      end
      do_reset("mid");
      add_init_exp();
      wait_idle("mid", 200);
      repeat (100) @(posedge clk);
      #1;
      check_writes("mid");
      check("mid_nbfall", bfall_q.size(), 1);
      if (bfall_q.size() > 0) check("mid_bfall", bfall_q[0] - mark, INIT_LEN);
      check("mid_ndone", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lcd_frame_sequencer.md
# lcd_frame_sequencer

Drives an HD44780-compatible 2x16 character LCD in 8-bit write-only mode from the seven ASCII characters produced by the elapsed-time block: minutes/seconds digits, the colon, and the two fraction digits. After power-up it runs the LCD init command sequence. On each refresh request it snapshots the characters and writes one frame: `MM:SS` on line 1 and the two fraction digits on line 2. It owns all LCD bus timing, enable-pulse generation and request coalescing, and sits between the timer datapath and the LCD pins.

## Interface
- `POWERUP_CYC`, 750000: idle cycles before the first init command (15 ms at 50 MHz).
- `EN_HIGH_CYC`, 25: cycles `lcd_en` is held high per write.
- `CHAR_WAIT_CYC`, 2500: post-pulse wait after every write except clear.
- `CLEAR_WAIT_CYC`, 100000: post-pulse wait after the clear command (0x01).
- `clk` in 1: system clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `update` in 1: single-cycle refresh request.
- `char1`..`char5` in 8 each: line 1 characters, in order M-tens, M-ones, ':', S-tens, S-ones.
- `char6`, `char7` in 8 each: line 2 characters, fraction tens and fraction ones.
- `lcd_data` out 8: LCD DB[7:0].
- `lcd_rs` out 1: 0 = command, 1 = data.
- `lcd_rw` out 1: constant 0.
- `lcd_en` out 1: LCD enable strobe.
- `busy` out 1: high during init and during any frame.
- `frame_done` out 1: one-cycle pulse at the end of each frame.

## Operation
- Top-level states: PWR_WAIT -> INIT -> IDLE <-> FRAME.
- Write engine (substates):
  - SETUP: 1 cycle; `lcd_en`=0; `lcd_data` and `lcd_rs` driven.
  - PULSE: `EN_HIGH_CYC` cycles; `lcd_en`=1.
  - WAIT: `CHAR_WAIT_CYC` or `CLEAR_WAIT_CYC` cycles; `lcd_en`=0.
  - `lcd_data` and `lcd_rs` hold from SETUP until the next write's SETUP.
- PWR_WAIT: wait `POWERUP_CYC` cycles, counting from the first cycle with `rst_n`=1.
- INIT: four commands with `lcd_rs`=0, in order 0x38, 0x0C, 0x06, 0x01. The last write uses `CLEAR_WAIT_CYC`. Then go to IDLE, or straight to FRAME if a request is pending.
- IDLE: `busy`=0. On `update`=1, capture `char1`..`char7` into a snapshot register and enter FRAME.
- FRAME: nine writes in order:
  - rs0/0x80
  - rs1/s1, rs1/s2, rs1/s3, rs1/s4, rs1/s5
  - rs0/0xC0
  - rs1/s6, rs1/s7
  - s1..s7 are the snapshot values, not the live inputs.
- End of FRAME: `frame_done`=1 for one cycle. Go to IDLE; if a request is pending, instead take a new snapshot and start the next frame on the following cycle.
- Pending flag:
  - Set by `update` during PWR_WAIT, INIT or FRAME; cleared when a frame starts.
  - Any number of requests while busy collapse into one extra frame.
  - `update` on the same cycle a frame ends also counts as pending.
- Character values are passed unmodified; there is no range checking.
- A frame never issues a clear command.

## Timing
- Reset values: `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_en`=0, `busy`=1, `frame_done`=0, pending=0; state PWR_WAIT.
- `rst_n` low in any state: at the next edge all outputs return to reset values (including `lcd_en` mid-pulse), and the full PWR_WAIT and INIT sequence restarts.
- Write cost: 1+`EN_HIGH_CYC`+wait cycles.
- Frame length: 9*(1+`EN_HIGH_CYC`+`CHAR_WAIT_CYC`) cycles.
- Init length: `POWERUP_CYC` + 3*(1+`EN_HIGH_CYC`+`CHAR_WAIT_CYC`) + (1+`EN_HIGH_CYC`+`CLEAR_WAIT_CYC`) cycles.
- Request latency: `update` sampled at edge k in IDLE gives, from edge k, `busy`=1, `lcd_rs`=0, `lcd_data`=0x80 (SETUP). `lcd_en` rises at edge k+1.
- End of frame with no request pending: `busy` falls on the same cycle `frame_done` pulses.
- Back-to-back frames:
  - `busy` stays 1 and `frame_done` still pulses.
  - The next SETUP is on the cycle after `frame_done`.
  - The snapshot is taken at that transition.

## Test plan
Sim parameters for all scenarios: `POWERUP_CYC`=20, `EN_HIGH_CYC`=2, `CHAR_WAIT_CYC`=5, `CLEAR_WAIT_CYC`=10.
- Reset, no update -> exactly four `lcd_en` pulses with rs=0 and data 0x38, 0x0C, 0x06, 0x01. `busy` falls 57 cycles after reset release. `frame_done` never asserts.
- After init, chars "12:34","0","8" plus one `update` -> rs/data sequence 0/80, 1/31, 1/32, 1/3A, 1/33, 1/34, 0/C0, 1/30, 1/38. Each pulse is 2 cycles wide; the frame is 72 cycles; exactly one `frame_done`.
- Change `char1`..`char7` to "59:59","9","9" while the third write is in progress -> the current frame still emits the "12:34"/"08" values.
- Three `update` pulses during a frame -> exactly one extra frame, starting the cycle after `frame_done` and carrying the inputs present at that cycle.
- `update` during PWR_WAIT -> the first frame's SETUP (0x80) follows the clear's wait immediately, with `busy` continuously 1.
- `rst_n`=0 for 1 cycle while `lcd_en`=1 mid-frame -> next cycle `lcd_en`=0, `lcd_data`=0x00, `busy`=1. The full 57-cycle init replays; the pending frame is lost.
